// File: rtl/morse_keyer_sched.sv
// morse_keyer_sched: 4-entry Morse symbol queue feeding a timed keyer.
// Marks key the carrier for 1 or 3 units, with a 1-unit gap after each mark.
// Char and word spaces hold the carrier low for 2 or 6 units.
// flush clears the queue, the FSM and the timers on the next clock edge.
module morse_keyer_sched #(
  parameter int unsigned UNIT_CYCLES = 12000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sym_valid,
  input  logic [1:0] sym_code,
  output logic       sym_ready,
  input  logic       flush,
  output logic       key_out,
  output logic       dot_stb,
  output logic       dash_stb,
  output logic       char_stb,
  output logic       word_stb,
  output logic       busy,
  output logic [2:0] fifo_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MARK = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [15:0] UNIT_LD = 16'(UNIT_CYCLES);
  localparam logic [2:0]  DEPTH   = 3'(FIFO_DEPTH);

  state_t      r_state;
  logic [1:0]  r_fifo [0:3];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic [15:0] r_cyc;
  logic [2:0]  r_units;
  logic        r_key;
  logic        r_dot_stb;
  logic        r_dash_stb;
  logic        r_char_stb;
  logic        r_word_stb;

  state_t      w_next_state;
  logic [15:0] w_cyc_nxt;
  logic [2:0]  w_units_nxt;
  logic        w_ready;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_head;

  assign w_ready = (r_count < DEPTH);
  assign w_push  = sym_valid & w_ready & ~flush;
  assign w_head  = r_fifo[r_rd_ptr];

  // Next-state, pop decision and unit/cycle timer update.
  always_comb begin
    w_next_state = r_state;
    w_cyc_nxt    = r_cyc;
    w_units_nxt  = r_units;
    w_pop        = 1'b0;
    if (flush) begin
      w_next_state = ST_IDLE;
      w_cyc_nxt    = 16'd0;
      w_units_nxt  = 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_count != 3'd0) begin
            w_pop     = 1'b1;
            w_cyc_nxt = UNIT_LD;
            case (w_head)
              2'b00:   begin w_next_state = ST_MARK; w_units_nxt = 3'd1; end
              2'b01:   begin w_next_state = ST_MARK; w_units_nxt = 3'd3; end
              2'b10:   begin w_next_state = ST_GAP;  w_units_nxt = 3'd2; end
              2'b11:   begin w_next_state = ST_GAP;  w_units_nxt = 3'd6; end
              default: begin w_next_state = ST_IDLE; w_units_nxt = 3'd0; end
            endcase
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_MARK, ST_GAP: begin
          if (r_cyc == 16'd1) begin
            if (r_units == 3'd1) begin
              if (r_state == ST_MARK) begin
                // Every mark is followed by a one-unit inter-element gap.
                w_next_state = ST_GAP;
                w_cyc_nxt    = UNIT_LD;
                w_units_nxt  = 3'd1;
              end else begin
                w_next_state = ST_IDLE;
                w_cyc_nxt    = 16'd0;
                w_units_nxt  = 3'd0;
              end
            end else begin
              w_units_nxt = r_units - 3'd1;
              w_cyc_nxt   = UNIT_LD;
            end
          end else begin
            w_cyc_nxt = r_cyc - 16'd1;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_cyc_nxt    = 16'd0;
          w_units_nxt  = 3'd0;
        end
      endcase
    end
  end

  // FSM state and timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cyc   <= 16'd0;
      r_units <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_cyc   <= w_cyc_nxt;
      r_units <= w_units_nxt;
    end
  end

  // Queue pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else if (flush) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage, written at the tail on each accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_fifo[i] <= 2'b00;
      end
    end else if (w_push) begin
      r_fifo[r_wr_ptr] <= sym_code;
    end
  end

  // Registered key and strobes: strobes mark the first cycle of MARK/GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key      <= 1'b0;
      r_dot_stb  <= 1'b0;
      r_dash_stb <= 1'b0;
      r_char_stb <= 1'b0;
      r_word_stb <= 1'b0;
    end else begin
      r_key      <= (w_next_state == ST_MARK);
      r_dot_stb  <= w_pop & (w_head == 2'b00);
      r_dash_stb <= w_pop & (w_head == 2'b01);
      r_char_stb <= w_pop & (w_head == 2'b10);
      r_word_stb <= w_pop & (w_head == 2'b11);
    end
  end

  assign sym_ready  = w_ready;
  assign key_out    = r_key;
  assign dot_stb    = r_dot_stb;
  assign dash_stb   = r_dash_stb;
  assign char_stb   = r_char_stb;
  assign word_stb   = r_word_stb;
  assign busy       = (r_state != ST_IDLE) | (r_count != 3'd0);
  assign fifo_count = r_count;

endmodule

// File: tb/tb_morse_keyer_sched.sv
// Bench for morse_keyer_sched (UNIT_CYCLES=2). It runs directed scenarios and
// a random phase. A timeline model predicts, for each popped symbol, the
// strobe cycle, the keyed interval and the cycle the keyer is free again.
module tb_morse_keyer_sched;
  localparam int U = 2;

  logic       clk;
  logic       rst_n;
  logic       sym_valid;
  logic [1:0] sym_code;
  logic       sym_ready;
  logic       flush;
  logic       key_out;
  logic       dot_stb;
  logic       dash_stb;
  logic       char_stb;
  logic       word_stb;
  logic       busy;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  // Timeline model state.
  int n;
  int q[$];
  int idle_at;
  int mark_start;
  int mark_end;
  int stb_cyc;
  int stb_code;

  morse_keyer_sched #(.UNIT_CYCLES(U), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_code(sym_code),
    .sym_ready(sym_ready), .flush(flush), .key_out(key_out),
    .dot_stb(dot_stb), .dash_stb(dash_stb), .char_stb(char_stb),
    .word_stb(word_stb), .busy(busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    idle_at    = n;
    mark_start = 0;
    mark_end   = 0;
    stb_cyc    = -1;
    stb_code   = 0;
  endtask

  // Compare all outputs against the timeline for the current cycle.
  task automatic check_cycle();
    chk("key_out",    {3'b0, key_out},  {3'b0, (n >= mark_start && n < mark_end) ? 1'b1 : 1'b0});
    chk("dot_stb",    {3'b0, dot_stb},  {3'b0, (n == stb_cyc && stb_code == 0) ? 1'b1 : 1'b0});
    chk("dash_stb",   {3'b0, dash_stb}, {3'b0, (n == stb_cyc && stb_code == 1) ? 1'b1 : 1'b0});
    chk("char_stb",   {3'b0, char_stb}, {3'b0, (n == stb_cyc && stb_code == 2) ? 1'b1 : 1'b0});
    chk("word_stb",   {3'b0, word_stb}, {3'b0, (n == stb_cyc && stb_code == 3) ? 1'b1 : 1'b0});
    chk("busy",       {3'b0, busy},     {3'b0, (n < idle_at || q.size() != 0) ? 1'b1 : 1'b0});
    chk("fifo_count", {1'b0, fifo_count}, 4'(q.size()));
    chk("sym_ready",  {3'b0, sym_ready}, {3'b0, (q.size() < 4) ? 1'b1 : 1'b0});
  endtask

  // Advance the timeline across one clock edge with the given inputs.
  task automatic model_edge(input logic v, input logic [1:0] c, input logic f);
    bit do_push;
    int s;
    if (f) begin
      q.delete();
      idle_at    = n + 1;
      mark_start = 0;
      mark_end   = 0;
      stb_cyc    = -1;
    end else begin
      do_push = v && (q.size() < 4);
      if (n >= idle_at && q.size() > 0) begin
        s        = q.pop_front();
        stb_cyc  = n + 1;
        stb_code = s;
        case (s)
          0: begin mark_start = n + 1; mark_end = n + 1 + U;     idle_at = mark_end + U; end
          1: begin mark_start = n + 1; mark_end = n + 1 + 3 * U; idle_at = mark_end + U; end
          2: idle_at = n + 1 + 2 * U;
          default: idle_at = n + 1 + 6 * U;
        endcase
      end
      if (do_push) q.push_back(int'(c));
    end
  endtask

  task automatic step(input logic v, input logic [1:0] c, input logic f);
    sym_valid = v;
    sym_code  = c;
    flush     = f;
    @(negedge clk);
    check_cycle();
    model_edge(v, c, f);
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 2'b00, 1'b0);
  endtask

  // Offer one symbol with sym_valid held until the queue takes it (bounded).
  task automatic offer(input logic [1:0] c);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = (q.size() < 4);
      step(1'b1, c, 1'b0);
    end
    chk("offer_accepted", {3'b0, acc}, 4'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    sym_valid = 1'b0;
    sym_code  = 2'b00;
    flush     = 1'b0;
    n         = 0;
    #12;
    chk("rst_key",   {3'b0, key_out},    4'd0);
    chk("rst_busy",  {3'b0, busy},       4'd0);
    chk("rst_count", {1'b0, fifo_count}, 4'd0);
    chk("rst_ready", {3'b0, sym_ready},  4'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Single dot.
    step(1'b1, 2'b00, 1'b0);
    idle(10);

    // Letter A: dot then dash back to back.
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b01, 1'b0);
    idle(20);

    // Full queue: five dashes offered with sym_valid held.
    for (int i = 0; i < 5; i++) offer(2'b01);
    idle(60);

    // Word space after a dash.
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    idle(30);

    // Flush during a dash mark with two symbols queued.
    step(1'b1, 2'b01, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b1);
    idle(12);

    // Asynchronous reset in the middle of a dot mark, then dot replay.
    step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    chk("pre_rst_key", {3'b0, key_out}, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_key",   {3'b0, key_out},    4'd0);
    chk("async_count", {1'b0, fifo_count}, 4'd0);
    chk("async_ready", {3'b0, sym_ready},  4'd1);
    chk("async_busy",  {3'b0, busy},       4'd0);
    @(posedge clk);
    #1;
    n++;
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 2'b00, 1'b0);
    idle(10);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end
    idle(80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
